// File: rtl/interrupt_controller.sv
// Prioritised interrupt controller: edge-latched pending bits, software mask, one vector in service at a time.
// Optional IRQ_SYNC_EN adds a 2-flop synchroniser on irq; the output is named intr because int is a reserved word.
module interrupt_controller #(
  parameter int NUM_IRQ   = 8,
  parameter int VEC_WIDTH = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_IRQ-1:0]   irq,
  input  logic                 mask_we,
  input  logic [NUM_IRQ-1:0]   mask_wdata,
  input  logic                 inta,
  input  logic                 eoi,
  output logic                 intr,
  output logic [VEC_WIDTH-1:0] vector,
  output logic                 busy,
  output logic [NUM_IRQ-1:0]   pending
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } state_t;

  state_t               state;
  logic [NUM_IRQ-1:0]   irq_s;
  logic [NUM_IRQ-1:0]   irq_prev;
  logic [NUM_IRQ-1:0]   mask;
  logic [NUM_IRQ-1:0]   rise;
  logic [NUM_IRQ-1:0]   eligible;
  logic [NUM_IRQ-1:0]   clr;
  logic [VEC_WIDTH-1:0] winner;

`ifdef IRQ_SYNC_EN
  logic [NUM_IRQ-1:0] sync_1;
  logic [NUM_IRQ-1:0] sync_2;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_1 <= '0;
      sync_2 <= '0;
    end else begin
      sync_1 <= irq;
      sync_2 <= sync_1;
    end
  end

  assign irq_s = sync_2;
`else
  assign irq_s = irq;
`endif

  assign rise     = irq_s & ~irq_prev;
  assign eligible = pending & ~mask;

  always_comb begin
    winner = '0;
    for (int k = NUM_IRQ - 1; k >= 0; k--) begin
      if (eligible[k]) winner = VEC_WIDTH'(k);
    end
  end

  // only the accepted vector is cleared; OR-ing rise afterwards lets a same-cycle set win
  always_comb begin
    clr = '0;
    if (state == REQ && inta) clr[vector] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      intr     <= 1'b0;
      vector   <= '0;
      busy     <= 1'b0;
      pending  <= '0;
      mask     <= '1;
      irq_prev <= '0;
    end else begin
      irq_prev <= irq_s;
      pending  <= (pending & ~clr) | rise;
      if (mask_we) mask <= mask_wdata;
      case (state)
        IDLE: begin
          if (|eligible) begin
            vector <= winner;
            intr   <= 1'b1;
            state  <= REQ;
          end
        end
        REQ: begin
          if (inta) begin
            intr  <= 1'b0;
            busy  <= 1'b1;
            state <= SERVICE;
          end
        end
        SERVICE: begin
          if (eoi) begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: begin
          intr  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_interrupt_controller.sv
// Directed bench for interrupt_controller (NUM_IRQ=8, no synchroniser).
// Inputs change 1ns after a rising edge; outputs are checked 1ns after the edge that updates them.
module tb_interrupt_controller;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] irq;
  logic       mask_we;
  logic [7:0] mask_wdata;
  logic       inta;
  logic       eoi;
  logic       intr;
  logic [2:0] vector;
  logic       busy;
  logic [7:0] pending;

  int total = 0;
  int bad   = 0;

  interrupt_controller #(.NUM_IRQ(8), .VEC_WIDTH(3)) dut (
    .clk        (clk),
    .rst        (rst),
    .irq        (irq),
    .mask_we    (mask_we),
    .mask_wdata (mask_wdata),
    .inta       (inta),
    .eoi        (eoi),
    .intr       (intr),
    .vector     (vector),
    .busy       (busy),
    .pending    (pending)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_inta();
    inta = 1'b1; tick(); inta = 1'b0;
  endtask

  task automatic pulse_eoi();
    eoi = 1'b1; tick(); eoi = 1'b0;
  endtask

  initial begin
    rst = 1'b1; irq = 8'h00; mask_we = 1'b0; mask_wdata = 8'h00; inta = 1'b0; eoi = 1'b0;
    #1;
    tick(); tick();
    rst = 1'b0;
    chk("rst_int", 32'(intr), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_pending", 32'(pending), 32'h00);
    chk("rst_vector", 32'(vector), 32'd0);

    // 1: single request, accept, end of interrupt
    mask_we = 1'b1; mask_wdata = 8'h00; tick(); mask_we = 1'b0;
    irq = 8'h08; tick();
    chk("t1_pending", 32'(pending), 32'h08);
    chk("t1_int_early", 32'(intr), 32'd0);
    tick();
    chk("t1_int", 32'(intr), 32'd1);
    chk("t1_vector", 32'(vector), 32'd3);
    pulse_inta();
    chk("t1_int_acc", 32'(intr), 32'd0);
    chk("t1_busy", 32'(busy), 32'd1);
    chk("t1_pending_clr", 32'(pending), 32'h00);
    pulse_eoi();
    chk("t1_busy_eoi", 32'(busy), 32'd0);
    irq = 8'h00; tick();

    // 2: simultaneous edges, priority then second vector
    irq = 8'h24; tick();
    chk("t2_pending", 32'(pending), 32'h24);
    tick();
    chk("t2_int", 32'(intr), 32'd1);
    chk("t2_vector_first", 32'(vector), 32'd2);
    pulse_inta();
    chk("t2_pending_after", 32'(pending), 32'h20);
    pulse_eoi();
    chk("t2_int_idle", 32'(intr), 32'd0);
    tick();
    chk("t2_int_again", 32'(intr), 32'd1);
    chk("t2_vector_second", 32'(vector), 32'd5);
    pulse_inta(); pulse_eoi();
    irq = 8'h00; tick();

    // 3: masked request released by mask write
    mask_we = 1'b1; mask_wdata = 8'h04; tick(); mask_we = 1'b0;
    irq = 8'h04; tick();
    chk("t3_pending", 32'(pending), 32'h04);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("t3_int_masked", 32'(intr), 32'd0);
    end
    mask_we = 1'b1; mask_wdata = 8'h00; tick(); mask_we = 1'b0;
    chk("t3_int_write_cycle", 32'(intr), 32'd0);
    tick();
    chk("t3_int", 32'(intr), 32'd1);
    chk("t3_vector", 32'(vector), 32'd2);
    pulse_inta(); pulse_eoi();
    irq = 8'h00; tick();

    // 4: reset while in service
    irq = 8'h02; tick(); tick();
    chk("t4_vector", 32'(vector), 32'd1);
    pulse_inta();
    chk("t4_busy", 32'(busy), 32'd1);
    rst = 1'b1; tick(); rst = 1'b0;
    chk("t4_int", 32'(intr), 32'd0);
    chk("t4_busy_rst", 32'(busy), 32'd0);
    chk("t4_pending", 32'(pending), 32'h00);
    chk("t4_vector_rst", 32'(vector), 32'd0);
    // irq[1] still high: counts as a fresh edge, but the reset mask holds it off
    tick();
    chk("t4_pending_held", 32'(pending), 32'h02);
    tick(); tick();
    chk("t4_mask_all", 32'(intr), 32'd0);
    irq = 8'h00;
    mask_we = 1'b1; mask_wdata = 8'h00; tick(); mask_we = 1'b0;
    tick();
    chk("t4_int_unmask", 32'(intr), 32'd1);
    chk("t4_vector_unmask", 32'(vector), 32'd1);
    pulse_inta(); pulse_eoi();

    // 5: held line gives one request; toggle during service gives another
    irq = 8'h10; tick(); tick();
    chk("t5_vector", 32'(vector), 32'd4);
    pulse_inta(); pulse_eoi();
    tick();
    chk("t5_no_repeat_int", 32'(intr), 32'd0);
    chk("t5_no_repeat_pend", 32'(pending), 32'h00);
    irq = 8'h00; tick();
    irq = 8'h10; tick(); tick();
    pulse_inta();
    chk("t5_busy", 32'(busy), 32'd1);
    irq = 8'h00; tick();
    irq = 8'h10; tick();
    chk("t5_pending_svc", 32'(pending), 32'h10);
    chk("t5_int_svc", 32'(intr), 32'd0);
    pulse_eoi();
    tick();
    chk("t5_int_after_eoi", 32'(intr), 32'd1);
    chk("t5_vector_after", 32'(vector), 32'd4);
    pulse_inta(); pulse_eoi();
    irq = 8'h00; tick();

    // 6: stray handshakes are ignored
    pulse_inta();
    chk("t6_idle_int", 32'(intr), 32'd0);
    chk("t6_idle_busy", 32'(busy), 32'd0);
    chk("t6_idle_pending", 32'(pending), 32'h00);
    irq = 8'h40; tick(); tick();
    chk("t6_req_int", 32'(intr), 32'd1);
    pulse_eoi();
    chk("t6_eoi_int", 32'(intr), 32'd1);
    chk("t6_eoi_busy", 32'(busy), 32'd0);
    chk("t6_eoi_pending", 32'(pending), 32'h40);
    chk("t6_eoi_vector", 32'(vector), 32'd6);
    pulse_inta();
    chk("t6_accept_busy", 32'(busy), 32'd1);
    pulse_eoi();
    chk("t6_final_busy", 32'(busy), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
